// File: rtl/aes_disp_pkg.sv
// Shared definitions for the AES result-byte display slice.
// Provides the display FSM state type, slice-wide sizes, and the
// double-dabble single-step helper used by the BCD converter.
package aes_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } disp_state_e;

    localparam int NUM_BYTES = 16;
    localparam int BCD_W     = 12;
    localparam int BYTE_W    = 8;
    localparam int DD_ITERS  = 8;
    localparam int DD_W      = BCD_W + BYTE_W;

    // One shift-and-add-3 step on the {bcd, binary} working register:
    // each BCD digit >= 5 is corrected by +3, then everything shifts left.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] sh);
        logic [DD_W-1:0] adj;
        adj = sh;
        for (int d = 0; d < 3; d++) begin
            if (adj[BYTE_W + 4*d +: 4] >= 4'd5) begin
                adj[BYTE_W + 4*d +: 4] = adj[BYTE_W + 4*d +: 4] + 4'd3;
            end else begin
                adj[BYTE_W + 4*d +: 4] = adj[BYTE_W + 4*d +: 4];
            end
        end
        return {adj[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a conversion of bin (first iteration on this edge)
//   bin         : 8-bit binary input, only sampled with start
//   busy        : conversion in progress
//   done        : high in the cycle whose edge completes the 8th iteration
//   bcd         : {hundreds,tens,ones}; valid for capture while done is high
module bin2bcd_seq
    import aes_disp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    logic [DD_W-1:0] sh_q, sh_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [DD_W-1:0] step_src_s, step_s;

    // Next-state for the working register and iteration count.
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        // On start the first iteration works directly on the fresh input,
        // so the full conversion takes exactly DD_ITERS edges.
        step_src_s = start ? {{BCD_W{1'b0}}, bin} : sh_q;
        step_s     = dd_step(step_src_s);
        if (start) begin
            sh_d   = step_s;
            cnt_d  = 3'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d   = step_s;
            cnt_d  = cnt_q + 3'd1;
            busy_d = (cnt_q != 3'(DD_ITERS - 1));
        end else begin
            sh_d   = sh_q;
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= {DD_W{1'b0}};
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && !start && (cnt_q == 3'(DD_ITERS - 1));
    assign bcd  = step_s[DD_W-1:BYTE_W];

endmodule

// File: rtl/aes_byte_display_seq.sv
// Captures a 128-bit AES result block (valid/ready), registers whether it
// equals a reference block, then walks its 16 bytes (FIPS-197 order),
// converting each to BCD and holding it on display for DWELL_CYCLES.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   blk_valid/blk_ready, blk_data, blk_expected : block handshake and data
//   hold          : pauses the dwell counter
//   byte_idx, byte_val : byte currently shown / being converted
//   bcd_out, bcd_valid : BCD of byte_val and its validity
//   match         : last accepted block equalled its reference
//   busy          : converting or showing
module aes_byte_display_seq
    import aes_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter bit LOOP         = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            blk_valid,
    output logic                            blk_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0]     blk_data,
    input  logic [NUM_BYTES*BYTE_W-1:0]     blk_expected,
    input  logic                            hold,
    output logic [3:0]                      byte_idx,
    output logic [BYTE_W-1:0]               byte_val,
    output logic [BCD_W-1:0]                bcd_out,
    output logic                            bcd_valid,
    output logic                            match,
    output logic                            busy
);

    localparam int             DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam int             BLK_W      = NUM_BYTES * BYTE_W;

    disp_state_e        state_q, state_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic [BYTE_W-1:0]  byte_val_q, byte_val_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               match_q, match_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [2:0]         iter_q, iter_d;
    logic               blk_ready_q, blk_ready_d;
    logic               busy_q, busy_d;

    logic               accept_s;
    logic [3:0]         next_idx_s;
    logic [BLK_W-1:0]   shifted_s;
    logic               conv_start_s, conv_busy_s, conv_done_s;
    logic [BCD_W-1:0]   conv_bcd_s;
    logic               last_stop_s;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start_s),
        .bin   (byte_val_q),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Display FSM: handshake, byte stepping, dwell and converter sequencing.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        byte_idx_d  = byte_idx_q;
        byte_val_d  = byte_val_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = bcd_valid_q;
        match_d     = match_q;
        dwell_d     = dwell_q;
        iter_d      = iter_q;

        // blk_ready_q is only high in IDLE/SHOW, so this also gates by state.
        accept_s     = blk_valid && blk_ready_q;
        next_idx_s   = byte_idx_q + 4'd1;
        // Byte 0 is the MSB byte, so shifting left brings byte n to the top.
        shifted_s    = buf_q << {next_idx_s, 3'b000};
        conv_start_s = (state_q == ST_CONV) && (iter_q == 3'd0) && !conv_busy_s;
        last_stop_s  = (byte_idx_q == 4'(NUM_BYTES - 1)) && (LOOP == 1'b0);

        if (accept_s) begin
            // A new block always wins, even on a dwell-expiry cycle.
            buf_d       = blk_data;
            match_d     = (blk_data == blk_expected);
            byte_idx_d  = 4'd0;
            byte_val_d  = blk_data[BLK_W-1 -: BYTE_W];
            bcd_valid_d = 1'b0;
            iter_d      = 3'd0;
            state_d     = ST_CONV;
        end else begin
            case (state_q)
                ST_CONV: begin
                    iter_d = iter_q + 3'd1;
                    if (conv_done_s) begin
                        bcd_out_d   = conv_bcd_s;
                        bcd_valid_d = 1'b1;
                        dwell_d     = {DW{1'b0}};
                        state_d     = ST_SHOW;
                    end else begin
                        state_d     = ST_CONV;
                    end
                end
                ST_SHOW: begin
                    if (hold) begin
                        dwell_d = dwell_q;
                    end else if (dwell_q == DWELL_LAST) begin
                        if (last_stop_s) begin
                            // Leave the final byte on display.
                            state_d = ST_IDLE;
                        end else begin
                            byte_idx_d  = next_idx_s;
                            byte_val_d  = shifted_s[BLK_W-1 -: BYTE_W];
                            bcd_valid_d = 1'b0;
                            iter_d      = 3'd0;
                            state_d     = ST_CONV;
                        end
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        blk_ready_d = (state_d != ST_CONV);
        busy_d      = (state_d != ST_IDLE);
    end

    // Display state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_q       <= {BLK_W{1'b0}};
            byte_idx_q  <= 4'd0;
            byte_val_q  <= {BYTE_W{1'b0}};
            bcd_out_q   <= {BCD_W{1'b0}};
            bcd_valid_q <= 1'b0;
            match_q     <= 1'b0;
            dwell_q     <= {DW{1'b0}};
            iter_q      <= 3'd0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            byte_idx_q  <= byte_idx_d;
            byte_val_q  <= byte_val_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            match_q     <= match_d;
            dwell_q     <= dwell_d;
            iter_q      <= iter_d;
            blk_ready_q <= blk_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign byte_idx  = byte_idx_q;
    assign byte_val  = byte_val_q;
    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign match     = match_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_byte_display_seq.sv
// Directed self-checking bench for aes_byte_display_seq (DWELL_CYCLES=4).
// Two instances share stimulus: dut (LOOP=1) and dut_nl (LOOP=0).
module tb_aes_byte_display_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic [127:0] blk_expected;
    logic         hold;

    logic         rdy, bv, mt, bsy;
    logic [3:0]   idx;
    logic [7:0]   bval;
    logic [11:0]  bcd;

    logic         rdy_nl, bv_nl, mt_nl, bsy_nl;
    logic [3:0]   idx_nl;
    logic [7:0]   bval_nl;
    logic [11:0]  bcd_nl;

    int checks = 0;
    int errors = 0;

    logic [127:0] blk_a;
    logic [127:0] blk_ff;
    logic [127:0] blk_ref;
    logic [11:0]  exp_a [16];
    int           n;
    int           k;
    logic         r;
    logic         acc;

    always #5 clk = ~clk;

    aes_byte_display_seq #(.DWELL_CYCLES(4), .LOOP(1'b1)) dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(rdy),
        .blk_data(blk_data), .blk_expected(blk_expected), .hold(hold),
        .byte_idx(idx), .byte_val(bval), .bcd_out(bcd), .bcd_valid(bv),
        .match(mt), .busy(bsy)
    );

    aes_byte_display_seq #(.DWELL_CYCLES(4), .LOOP(1'b0)) dut_nl (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(rdy_nl),
        .blk_data(blk_data), .blk_expected(blk_expected), .hold(hold),
        .byte_idx(idx_nl), .byte_val(bval_nl), .bcd_out(bcd_nl), .bcd_valid(bv_nl),
        .match(mt_nl), .busy(bsy_nl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until dut shows byte 'want' with bcd_valid; cnt = edges taken.
    task automatic wait_show(input logic [3:0] want, output int cnt);
        cnt = 0;
        while (!(bv === 1'b1 && idx === want) && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("wait_show_timeout", 128'(cnt < 60), 128'd1);
    endtask

    initial begin
        blk_a   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        blk_ff  = {128{1'b1}};
        blk_ref = 128'h00112233445566778899aabbccddeeff;
        exp_a   = '{12'h105, 12'h196, 12'h224, 12'h216, 12'h106, 12'h123, 12'h004, 12'h048,
                    12'h216, 12'h205, 12'h183, 12'h128, 12'h112, 12'h180, 12'h197, 12'h090};

        reset = 1'b1; blk_valid = 1'b0; blk_data = 128'd0; blk_expected = 128'd0; hold = 1'b0;
        tick(); tick();
        chk("rst_ready", 128'(rdy), 128'd1);
        chk("rst_idx", 128'(idx), 128'd0);
        chk("rst_bval", 128'(bval), 128'd0);
        chk("rst_bcd", 128'(bcd), 128'd0);
        chk("rst_bv", 128'(bv), 128'd0);
        chk("rst_match", 128'(mt), 128'd0);
        chk("rst_busy", 128'(bsy), 128'd0);
        reset = 1'b0;
        tick();

        // Block A, expected equal.
        blk_data = blk_a; blk_expected = blk_a; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk("acc_ready_low", 128'(rdy), 128'd0);
        chk("acc_match", 128'(mt), 128'd1);
        chk("acc_idx", 128'(idx), 128'd0);
        chk("acc_bval", 128'(bval), 128'h69);
        chk("acc_busy", 128'(bsy), 128'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("conv_7_bv_low", 128'(bv), 128'd0);
        chk("conv_bcd_kept", 128'(bcd), 128'd0);
        tick();
        chk("conv_8_bv", 128'(bv), 128'd1);
        chk("byte0_bcd", 128'(bcd), 128'(exp_a[0]));

        wait_show(4'd1, n);
        chk("byte1_period", 128'(n), 128'd12);
        chk("byte1_bcd", 128'(bcd), 128'(exp_a[1]));
        for (int i = 2; i < 16; i++) begin
            wait_show(4'(i), n);
            chk($sformatf("byteA_%0d_bcd", i), 128'(bcd), 128'(exp_a[i]));
        end
        chk("byte15_bcd_nl", 128'(bcd_nl), 128'h090);

        // Dwell of the last byte expires: LOOP=0 stops, LOOP=1 wraps.
        for (int i = 0; i < 4; i++) tick();
        chk("nl_busy", 128'(bsy_nl), 128'd0);
        chk("nl_ready", 128'(rdy_nl), 128'd1);
        chk("nl_idx", 128'(idx_nl), 128'd15);
        chk("nl_bval", 128'(bval_nl), 128'h5a);
        chk("nl_bv", 128'(bv_nl), 128'd1);
        chk("nl_bcd", 128'(bcd_nl), 128'h090);
        chk("nl_match", 128'(mt_nl), 128'd1);
        chk("wrap_idx", 128'(idx), 128'd0);
        chk("wrap_bv", 128'(bv), 128'd0);
        wait_show(4'd0, n);
        chk("wrap_bcd", 128'(bcd), 128'h105);

        // Hold: two dwell cycles, pause 10, then two more to advance.
        tick(); tick();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_idx", 128'(idx), 128'd0);
        chk("hold_bcd", 128'(bcd), 128'h105);
        chk("hold_bv", 128'(bv), 128'd1);
        hold = 1'b0;
        tick();
        chk("release_1_idx", 128'(idx), 128'd0);
        tick();
        chk("release_2_idx", 128'(idx), 128'd1);
        chk("release_2_bv", 128'(bv), 128'd0);

        // Offer a block during CONV: held off until SHOW.
        blk_data = blk_ff; blk_expected = blk_ref; blk_valid = 1'b1;
        chk("conv_ready_low", 128'(rdy), 128'd0);
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            r = rdy;
            tick();
            k++;
            if (r) acc = 1'b1;
        end
        blk_valid = 1'b0;
        chk("conv_accept_edges", 128'(k), 128'd9);
        chk("ff_match", 128'(mt), 128'd0);
        chk("ff_idx", 128'(idx), 128'd0);
        chk("ff_bval", 128'(bval), 128'hff);
        chk("ff_bv", 128'(bv), 128'd0);
        chk("ff_bcd_kept", 128'(bcd), 128'h196);
        wait_show(4'd0, n);
        chk("ff_latency", 128'(n), 128'd8);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_show(4'(i), n);
            chk($sformatf("ff_%0d_bcd", i), 128'(bcd), 128'h255);
        end

        // New block on the dwell-expiry cycle: accept wins.
        tick(); tick(); tick();
        blk_data = 128'd0; blk_expected = 128'd0; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk("exp_acc_idx", 128'(idx), 128'd0);
        chk("exp_acc_bval", 128'(bval), 128'd0);
        chk("exp_acc_match", 128'(mt), 128'd1);
        chk("exp_acc_bv", 128'(bv), 128'd0);
        wait_show(4'd0, n);
        chk("zero_bcd", 128'(bcd), 128'h000);

        // Reset in the middle of CONV.
        blk_data = blk_a; blk_expected = blk_ref; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk("mid_match", 128'(mt), 128'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("mr_ready", 128'(rdy), 128'd1);
        chk("mr_idx", 128'(idx), 128'd0);
        chk("mr_bval", 128'(bval), 128'd0);
        chk("mr_bcd", 128'(bcd), 128'd0);
        chk("mr_bv", 128'(bv), 128'd0);
        chk("mr_match", 128'(mt), 128'd0);
        chk("mr_busy", 128'(bsy), 128'd0);
        tick();
        reset = 1'b0;
        tick();

        // Normal operation after reset.
        blk_data = blk_a; blk_expected = blk_a; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        wait_show(4'd0, n);
        chk("post_rst_latency", 128'(n), 128'd8);
        chk("post_rst_bcd", 128'(bcd), 128'h105);
        chk("post_rst_match", 128'(mt), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
